// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter for the GPIO peripheral port.
// Registered grants, optional lock bounded by a hold limit.
module gpio_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m1_req_i,
  input  logic              m0_lock_i,
  input  logic              m1_lock_i,
  input  logic              m0_we_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } owner_e;

  owner_e          owner_q, owner_d;
  logic            last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            own_req, own_lock, oth_req, keep;
  logic            xfer0, xfer1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    unique case (owner_q)
      OWN0: begin
        own_req  = m0_req_i;
        own_lock = m0_lock_i;
        oth_req  = m1_req_i;
      end
      OWN1: begin
        own_req  = m1_req_i;
        own_lock = m1_lock_i;
        oth_req  = m0_req_i;
      end
      default: ;
    endcase

    keep = own_req & own_lock
         & (~oth_req | (hold_q < HOLD_MAX));

    owner_d = IDLE;
    if (keep)
      owner_d = owner_q;
    else if (m0_req_i && m1_req_i)
      owner_d = last_q ? OWN0 : OWN1;
    else if (m0_req_i)
      owner_d = OWN0;
    else if (m1_req_i)
      owner_d = OWN1;

    last_d = last_q;
    if (owner_d == OWN0)
      last_d = 1'b0;
    else if (owner_d == OWN1)
      last_d = 1'b1;

    // Count only locked cycles that actually block a waiting master.
    hold_d = '0;
    if (owner_q != IDLE && owner_d == owner_q
        && own_lock && oth_req)
      hold_d = (hold_q == HOLD_MAX) ? hold_q
                                    : hold_q + 1'b1;
  end

  assign m0_gnt_o = (owner_q == OWN0);
  assign m1_gnt_o = (owner_q == OWN1);

  assign xfer0 = m0_gnt_o & m0_req_i;
  assign xfer1 = m1_gnt_o & m1_req_i;

  assign s_we_o   = (xfer0 & m0_we_i) | (xfer1 & m1_we_i);
  assign s_addr_o = xfer0 ? m0_addr_i
                  : xfer1 ? m1_addr_i : '0;
  assign s_data_o = xfer0 ? m0_data_i
                  : xfer1 ? m1_data_i : '0;

  assign m0_data_o = m0_gnt_o ? s_data_i : '0;
  assign m1_data_o = m1_gnt_o ? s_data_i : '0;

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Two-master arbiter that shares the single memory-mapped peripheral port of the GPIO block (and any peripheral hung on the same port) between the core data port (master 0) and the debug master (master 1). It registers a grant per cycle and arbitrates round-robin. It supports a lock for multi-cycle read-modify-write sequences, bounded by a hold limit so the other master cannot starve. Slave-side signals are zero when no master owns the port.

## Interface
- ADDR_W, 32, address width of master and slave ports
- DATA_W, 32, data width
- MAX_HOLD, 8, max consecutive locked grant cycles while the other master is requesting (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; **asynchronous, active-high**
- m0_req_i / m1_req_i  in  1  transfer request
- m0_lock_i / m1_lock_i  in  1  keep ownership across cycles
- m0_we_i / m1_we_i  in  1  write enable (1 = write, 0 = read)
- m0_addr_i / m1_addr_i  in  ADDR_W  address
- m0_data_i / m1_data_i  in  DATA_W  write data
- m0_gnt_o / m1_gnt_o  out  1  registered grant
- m0_data_o / m1_data_o  out  DATA_W  read data; s_data_i when granted, else 0
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_W  slave address
- s_data_o  out  DATA_W  slave write data
- s_data_i  in  DATA_W  slave read data (combinational from slave)

## Operation
- State: owner ∈ {IDLE, OWN0, OWN1}, last_owner (1 bit), hold_cnt (counts to MAX_HOLD-1, saturating).
- m0_gnt_o = (owner==OWN0); m1_gnt_o = (owner==OWN1); the two are never both high.
- A transfer occurs in any cycle where gnt_x and req_x are both high.
  - s_we_o = gnt_x & req_x & we_x.
  - s_addr_o and s_data_o come from the owner when gnt_x & req_x, else 0.
- Next-owner rule, evaluated every cycle from the current inputs:
  1. **Keep.** If owner is OWNx, req_x=1, lock_x=1, and (other req=0 or hold_cnt < MAX_HOLD-1): next = OWNx.
  2. **Arbitrate.** Otherwise:
     - both requesting: next = the master ≠ last_owner;
     - one requesting: next = that master;
     - none requesting: next = IDLE.
- hold_cnt:
  - increments when the next owner equals the current non-IDLE owner, the owner's lock is high, and the other master is requesting;
  - clears on any owner change, on lock low, or when the other master is not requesting.
- last_owner updates to x whenever the next owner is OWNx.
- Without lock, a sole requester keeps its grant every cycle (one transfer per cycle). Two requesters alternate cycle by cycle.
- A master must hold req/we/addr/data stable until it sees gnt with its req high. The transfer completes in that cycle.

## Timing
- Reset values:
  - owner=IDLE, last_owner=1 (master 0 wins the first tie), hold_cnt=0;
  - all gnt_o=0, s_we_o=0, s_addr_o=0, s_data_o=0, m*_data_o=0.
- Grant latency: req rising in cycle N (port idle) → gnt high in N+1, transfer in N+1.
- Switch latency: owner drops req in cycle N → its gnt is still high in N but there is no transfer (s_we_o=0). The other master gets gnt in N+1 if requesting.
- Read data is combinational: m_x_data_o = s_data_i in the same cycle as the granted read.
- Hold limit: with MAX_HOLD=H and the other master requesting continuously, a locked owner keeps at most H consecutive grant cycles. The other master is then granted for ≥1 cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous) and no write is issued. After release, arbitration restarts from IDLE with master 0 preferred.
- MAX_HOLD=1: lock never extends ownership while the other master is requesting.

## Test plan
1. **Single write.** After reset, m0 requests write addr=0x4, data=0x3 in cycle 0 → m0_gnt_o=1 in cycle 1 with s_we_o=1, s_addr_o=0x4, s_data_o=0x3. Drop req → gnt low by cycle 3.
2. **Alternation.** m0 and m1 request continuously without lock from IDLE → grants m0, m1, m0, m1 in cycles 1–4. s_we_o is never high with both gnts.
3. **Hold limit.** m0 locked and requesting with MAX_HOLD=8, m1 requests from cycle 2 → m0 is granted for 8 consecutive cycles with m1 requesting, then m1 is granted for 1 cycle, then m0 again.
4. **Read isolation.** m1 granted read addr=0x0, s_data_i=0xA5 → m1_data_o=0xA5, m0_data_o=0, s_we_o=0.
5. **Reset mid-write.** rst pulsed while m1 is granted mid-write → gnt, s_we_o and s_addr_o are 0 within the same cycle. After release with both requesting, m0 is granted first.
6. **Owner drops request.** m0 is owner and deasserts req in cycle N while m1 is requesting → no transfer in cycle N, and m1_gnt_o=1 in cycle N+1.
